instr_exec_sequencer: RTL and testbench

Downstream consumer of the instruction register. On a start pulse it walks `read_pointer` through a window of stored instructions and latches each `instruction_word`. It executes the opcode: single-cycle ops directly, DIV/MOD via an iterative divider. Each result is presented on a valid/ready output port to the checker/scoreboard side.

---
 rtl/instr_register_pkg.sv | 41 ++++
 rtl/instr_exec_sequencer_if.sv | 36 +++
 rtl/instr_exec_sequencer_divider.sv | 75 +++++++
 rtl/instr_exec_sequencer.sv | 159 +++++++++++++++
 tb/tb_instr_exec_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared types and constants for the instruction execution sequencer
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_DIVIDE = 3'd3,
        S_OUTPUT = 3'd4,
        S_DONE   = 3'd5
    } exec_state_t;

    localparam int DIV_CYCLES = 32;

    // Unsigned magnitude of a signed operand; -2^31 maps to 2^31, which still fits in 32 bits.
    function automatic logic [31:0] magnitude(input operand_t v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

endpackage

// File: rtl/instr_exec_sequencer_if.sv
// rtl/instr_exec_sequencer_if.sv - instruction read port and result handshake bundle
interface instr_exec_sequencer_if;
    import instr_register_pkg::*;

    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      res_data;
    address_t     res_addr;
    opcode_t      res_opcode;
    logic         res_err;

    modport master (
        output read_pointer,
        input  instruction_word,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_addr,
        output res_opcode,
        output res_err
    );

    modport slave (
        input  read_pointer,
        output instruction_word,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_addr,
        input  res_opcode,
        input  res_err
    );

endinterface

// File: rtl/instr_exec_sequencer_divider.sv
// rtl/instr_exec_sequencer_divider.sv - unsigned 32/32 restoring divider, one quotient bit per cycle
module iter_divider
    import instr_register_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] rem_src;
    logic [31:0] quot_src;
    logic [31:0] dsr_src;
    logic [31:0] divisor_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [5:0]  steps;
    logic        running;

    // One restoring step; on start the first step is taken straight from the inputs so the
    // whole division finishes in DIV_CYCLES edges counted from the start edge.
    always_comb begin
        rem_src  = start ? 32'd0    : remainder;
        quot_src = start ? dividend : quotient;
        dsr_src  = start ? divisor  : divisor_q;
        shifted  = {rem_src, quot_src[31]};
        diff     = shifted - {1'b0, dsr_src};
        if (!diff[32]) begin
            rem_next  = diff[31:0];
            quot_next = {quot_src[30:0], 1'b1};
        end else begin
            rem_next  = shifted[31:0];
            quot_next = {quot_src[30:0], 1'b0};
        end
    end

    // Iteration registers; done pulses for one cycle after the last quotient bit lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient  <= '0;
            remainder <= '0;
            divisor_q <= '0;
            steps     <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                running <= 1'b0;
            end else if (start) begin
                quotient  <= quot_next;
                remainder <= rem_next;
                divisor_q <= divisor;
                steps     <= 6'd1;
                running   <= 1'b1;
            end else if (running) begin
                quotient  <= quot_next;
                remainder <= rem_next;
                steps     <= steps + 6'd1;
                if (steps == 6'(DIV_CYCLES - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_exec_sequencer.sv
// rtl/instr_exec_sequencer.sv - walks a window of stored instructions, executes each and streams results
module instr_exec_sequencer
    import instr_register_pkg::*;
#(
    parameter int COUNT_W   = 6,
    parameter int REG_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  address_t               start_addr,
    input  logic [COUNT_W-1:0]     count,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    instr_exec_sequencer_if.master bus
);

    exec_state_t        state;
    exec_state_t        state_next;
    instruction_t       instr;
    logic [COUNT_W-1:0] remaining;
    logic               div_start;
    logic               div_done;
    logic               is_div;
    logic               div_zero;
    logic               accept;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [63:0]        quo_ext;
    logic [63:0]        rem_ext;
    result_t            alu_result;
    result_t            div_result;
    address_t           ptr_next;

    assign is_div   = (instr.opc == DIV) || (instr.opc == MOD);
    assign div_zero = (instr.op_b == '0);
    assign accept   = (state == S_OUTPUT) && bus.res_ready;
    assign ptr_next = (bus.read_pointer == address_t'(REG_DEPTH - 1)) ? '0 : bus.read_pointer + 5'd1;

    assign bus.res_valid = (state == S_OUTPUT);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    iter_divider u_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .cancel    (abort),
        .dividend  (magnitude(instr.op_a)),
        .divisor   (magnitude(instr.op_b)),
        .quotient  (quo_u),
        .remainder (rem_u),
        .done      (div_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; abort wins over everything except IDLE and the closing DONE cycle.
    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = (count == '0) ? S_DONE : S_FETCH;
            S_FETCH:  state_next = S_EXEC;
            S_EXEC: begin
                if (is_div && !div_zero) begin
                    state_next = S_DIVIDE;
                    div_start  = 1'b1;
                end else begin
                    state_next = S_OUTPUT;
                end
            end
            S_DIVIDE: if (div_done) state_next = S_OUTPUT;
            S_OUTPUT: if (accept) state_next = (remaining == COUNT_W'(1)) ? S_DONE : S_FETCH;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort && (state != S_IDLE) && (state != S_DONE)) begin
            state_next = S_DONE;
            div_start  = 1'b0;
        end
    end

    // Single-cycle ALU at full 64-bit width; divide-by-zero and unknown encodings give 0.
    always_comb begin
        alu_result = '0;
        case (instr.opc)
            ZERO:    alu_result = '0;
            PASSA:   alu_result = result_t'($signed(instr.op_a));
            PASSB:   alu_result = result_t'($signed(instr.op_b));
            ADD:     alu_result = result_t'($signed(instr.op_a)) + result_t'($signed(instr.op_b));
            SUB:     alu_result = result_t'($signed(instr.op_a)) - result_t'($signed(instr.op_b));
            MULT:    alu_result = result_t'($signed(instr.op_a)) * result_t'($signed(instr.op_b));
            default: alu_result = '0;
        endcase
    end

    // Sign fix-up: quotient negative when operand signs differ, remainder follows the dividend.
    always_comb begin
        quo_ext = {32'd0, quo_u};
        rem_ext = {32'd0, rem_u};
        if (instr.opc == DIV)
            div_result = result_t'((instr.op_a[31] ^ instr.op_b[31]) ? -quo_ext : quo_ext);
        else
            div_result = result_t'(instr.op_a[31] ? -rem_ext : rem_ext);
    end

    // Datapath: pointer/count bookkeeping, instruction capture and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.read_pointer <= '0;
            remaining        <= '0;
            instr            <= '0;
            bus.res_data     <= '0;
            bus.res_addr     <= '0;
            bus.res_opcode   <= ZERO;
            bus.res_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bus.read_pointer <= start_addr;
                        remaining        <= count;
                    end
                end
                S_FETCH: instr <= bus.instruction_word;
                S_EXEC: begin
                    if (!(is_div && !div_zero)) begin
                        bus.res_data   <= alu_result;
                        bus.res_err    <= is_div;
                        bus.res_addr   <= bus.read_pointer;
                        bus.res_opcode <= instr.opc;
                    end
                end
                S_DIVIDE: begin
                    if (div_done) begin
                        bus.res_data   <= div_result;
                        bus.res_err    <= 1'b0;
                        bus.res_addr   <= bus.read_pointer;
                        bus.res_opcode <= instr.opc;
                    end
                end
                S_OUTPUT: begin
                    if (accept) begin
                        bus.read_pointer <= ptr_next;
                        remaining        <= remaining - COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// tb/tb_instr_exec_sequencer.sv - randomized self-checking bench for instr_exec_sequencer
module tb_instr_exec_sequencer;
    import instr_register_pkg::*;

    typedef struct {
        address_t addr;
        opcode_t  opc;
        longint   data;
        logic     err;
        int       lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    address_t    start_addr = '0;
    logic [5:0]  count = '0;
    logic        busy;
    logic        done;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    instruction_t mem [32];
    exp_t         expq [$];

    instr_exec_sequencer_if bus ();

    instr_exec_sequencer #(.COUNT_W(6), .REG_DEPTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb bus.instruction_word = mem[bus.read_pointer];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the arithmetic rules, using 64-bit integer operators.
    function automatic exp_t model(input address_t a, input instruction_t w);
        exp_t   e;
        longint x = longint'($signed(w.op_a));
        longint y = longint'($signed(w.op_b));
        e.addr = a;
        e.opc  = w.opc;
        e.err  = 1'b0;
        e.lat  = 3;
        case (w.opc)
            PASSA: e.data = x;
            PASSB: e.data = y;
            ADD:   e.data = x + y;
            SUB:   e.data = x - y;
            MULT:  e.data = x * y;
            DIV, MOD: begin
                if (y == 0) begin
                    e.data = 0;
                    e.err  = 1'b1;
                end else begin
                    e.data = (w.opc == DIV) ? x / y : x % y;
                    e.lat  = 35;
                end
            end
            default: e.data = 0;
        endcase
        return e;
    endfunction

    function automatic operand_t rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'sd0;
            1: return -32'sd1;
            2: return 32'sh80000000;
            3: return 32'sh7fffffff;
            4: return operand_t'($urandom_range(0, 20)) - 32'sd10;
            default: return operand_t'($urandom);
        endcase
    endfunction

    function automatic instruction_t rnd_instr(input bit allow_div);
        instruction_t w;
        w.opc  = opcode_t'(allow_div ? $urandom_range(0, 7) : $urandom_range(0, 5));
        w.op_a = rnd_op();
        w.op_b = rnd_op();
        return w;
    endfunction

    task automatic check_reset_outputs(input string where);
        check({where, "_busy"},      64'(busy), 64'd0);
        check({where, "_done"},      64'(done), 64'd0);
        check({where, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({where, "_read_ptr"},  64'(bus.read_pointer), 64'd0);
        check({where, "_res_data"},  bus.res_data, 64'd0);
        check({where, "_res_addr"},  64'(bus.res_addr), 64'd0);
        check({where, "_res_opc"},   64'(bus.res_opcode), 64'(ZERO));
        check({where, "_res_err"},   64'(bus.res_err), 64'd0);
    endtask

    // One run: model the expected result stream, then consume it with optional back-pressure.
    task automatic run(input int sa, input int cnt, input int stall_idx, input int stall_len,
                       input bit rand_stall, input bit poke);
        exp_t e;
        int   ref_cyc;
        int   waited;
        int   n_stall;
        for (int i = 0; i < cnt; i++) begin
            address_t a = address_t'(sa + i);
            expq.push_back(model(a, mem[a]));
        end
        @(negedge clk);
        start = 1'b1;
        start_addr = address_t'(sa);
        count = 6'(cnt);
        @(negedge clk);
        start = 1'b0;
        ref_cyc = cyc;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < cnt; i++) begin
            e = expq.pop_front();
            waited = 0;
            while (!bus.res_valid && waited < 60) begin
                if (poke && i == 0 && waited == 5) begin
                    start = 1'b1;
                    start_addr = address_t'(sa + 7);
                    count = 6'd9;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                waited++;
            end
            start = 1'b0;
            check("valid_timeout", 64'(bus.res_valid), 64'd1);
            check("latency",  64'(cyc + 1 - ref_cyc), 64'(e.lat));
            check("res_data", bus.res_data, e.data);
            check("res_addr", 64'(bus.res_addr), 64'(e.addr));
            check("res_opc",  64'(bus.res_opcode), 64'(e.opc));
            check("res_err",  64'(bus.res_err), 64'(e.err));
            n_stall = (i == stall_idx) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            repeat (n_stall) begin
                @(negedge clk);
                check("stall_valid", 64'(bus.res_valid), 64'd1);
                check("stall_data",  bus.res_data, e.data);
                check("stall_addr",  64'(bus.res_addr), 64'(e.addr));
                check("stall_ptr",   64'(bus.read_pointer), 64'(e.addr));
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            ref_cyc = cyc;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("done_no_valid", 64'(bus.res_valid), 64'd0);
        @(negedge clk);
        check("done_clear", 64'(done), 64'd0);
        check("idle_busy",  64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        mem[3] = '{opc: ADD, op_a: 32'sd5, op_b: 32'sd7};
        run(3, 1, -1, 0, 1'b0, 1'b0);
        mem[0] = '{opc: DIV, op_a: -32'sd7, op_b: 32'sd2};
        mem[1] = '{opc: MOD, op_a: -32'sd7, op_b: 32'sd2};
        run(0, 2, -1, 0, 1'b0, 1'b0);
        mem[4] = '{opc: DIV, op_a: 32'sd9, op_b: 32'sd0};
        run(4, 1, -1, 0, 1'b0, 1'b0);
        mem[6] = '{opc: DIV, op_a: 32'sh80000000, op_b: -32'sd1};
        mem[7] = '{opc: MOD, op_a: 32'sh80000000, op_b: -32'sd1};
        mem[8] = '{opc: MULT, op_a: 32'sh80000000, op_b: 32'sh80000000};
        run(6, 3, -1, 0, 1'b0, 1'b0);
        mem[30] = '{opc: SUB, op_a: 32'sh80000000, op_b: 32'sd1};
        mem[31] = '{opc: PASSB, op_a: 32'sd3, op_b: -32'sd4};
        run(30, 4, 1, 5, 1'b0, 1'b0);
        run(9, 0, -1, 0, 1'b0, 1'b0);

        // Start while busy must be ignored.
        mem[10] = '{opc: DIV, op_a: 32'sd1000, op_b: -32'sd7};
        run(10, 1, -1, 0, 1'b0, 1'b1);

        // Abort during FETCH.
        mem[5] = '{opc: ADD, op_a: 32'sd1, op_b: 32'sd1};
        @(negedge clk);
        start = 1'b1; start_addr = 5'd5; count = 6'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done",  64'(done), 64'd1);
        check("abort_valid", 64'(bus.res_valid), 64'd0);
        check("abort_ptr",   64'(bus.read_pointer), 64'd5);
        @(negedge clk);
        check("abort_idle",  64'(busy), 64'd0);
        check("abort_valid2", 64'(bus.res_valid), 64'd0);

        // Asynchronous reset in the middle of a divide.
        mem[12] = '{opc: DIV, op_a: 32'sd100, op_b: 32'sd3};
        @(negedge clk);
        start = 1'b1; start_addr = 5'd12; count = 6'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || bus.res_valid || busy) seen++;
        end
        check("post_reset_quiet", 64'(seen), 64'd0);

        // Count above the register depth re-reads entries.
        for (int i = 0; i < 32; i++) mem[i] = rnd_instr(1'b0);
        run(int'($urandom_range(0, 31)), 40, -1, 0, 1'b1, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = rnd_instr(1'b1);
            run(int'($urandom_range(0, 31)), int'($urandom_range(1, 6)), -1, 0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
